itf_rx: RTL and testbench



---
 rtl/itf_rx_pkg.sv | 20 ++
 rtl/itf_rx_if.sv | 25 ++
 rtl/itf_rx_sync.sv | 24 ++
 rtl/itf_rx.sv | 149 ++++++++++++++
 tb/tb_itf_rx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/itf_rx_pkg.sv
// Shared types and defaults for the itf_rx UART receiver.
package itf_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int CLK_PER_BIT_DEF = 868;
    localparam int PACK_SIZE_DEF   = 8;

    // Expected parity bit from the XOR-reduction of the data word.
    function automatic logic parity_bit(input logic data_xor, input logic even);
        return data_xor ^ ~even;
    endfunction

endpackage

// File: rtl/itf_rx_if.sv
// Receiver-side signal bundle: serial line in, parallel word and status out.
interface itf_rx_if
    import itf_rx_pkg::*;
#(
    parameter int PACK_SIZE = PACK_SIZE_DEF
) ();

    logic                 rx_bit;
    logic [PACK_SIZE-1:0] rx_byte_data;
    logic                 rx_byte_valid;
    logic                 rx_active;
    logic                 par_error;
    logic                 stop_error;

    modport master (
        output rx_bit,
        input  rx_byte_data, rx_byte_valid, rx_active, par_error, stop_error
    );

    modport slave (
        input  rx_bit,
        output rx_byte_data, rx_byte_valid, rx_active, par_error, stop_error
    );

endinterface

// File: rtl/itf_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle level (1).
module itf_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/itf_rx.sv
// UART frame receiver: start, PACK_SIZE data bits LSB first, optional parity, one stop bit.
// Define ITF_RX_ERR_EN to drive par_error/stop_error; otherwise both are tied low.
module itf_rx
    import itf_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int PACK_SIZE   = PACK_SIZE_DEF,
    parameter bit PARITY_EN   = 1'b0,
    parameter bit EVEN_PAR    = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    itf_rx_if.slave  rx
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(PACK_SIZE);

    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PACK_SIZE - 1);

    logic rx_s;

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PACK_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 active_q, active_d;
    logic                 par_err_q, par_err_d;
    logic                 stop_err_q, stop_err_d;
    logic                 flag_q, flag_d;

    itf_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx.rx_bit),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            flag_q     <= flag_d;
        end
    end

    // Strobes and error pulses default low so each lasts exactly one cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        active_d   = active_q;
        flag_d     = flag_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                flag_d = 1'b0;
                if (!rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s;
                    idx_d         = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (rx_s != parity_bit(^data_q, EVEN_PAR)) begin
                        flag_d = 1'b1;
`ifdef ITF_RX_ERR_EN
                        par_err_d = 1'b1;
`endif
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    valid_d  = rx_s & ~flag_q;
                    active_d = 1'b0;
                    state_d  = IDLE;
`ifdef ITF_RX_ERR_EN
                    stop_err_d = ~rx_s;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    assign rx.rx_byte_data  = data_q;
    assign rx.rx_byte_valid = valid_q;
    assign rx.rx_active     = active_q;
    assign rx.par_error     = par_err_q;
    assign rx.stop_error    = stop_err_q;

endmodule

// File: tb/tb_itf_rx.sv
// Scoreboard bench for itf_rx: two instances (with and without parity), frame-end monitor.
module tb_itf_rx;
    import itf_rx_pkg::*;

    localparam int CPB = 5;
`ifdef ITF_RX_ERR_EN
    localparam int ERR = 1;
`else
    localparam int ERR = 0;
`endif
    // Cycles from rx_active rising to rx_byte_valid, per instance.
    localparam int LAT_A = 11 * CPB - 2;
    localparam int LAT_B = 10 * CPB - 2;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       stop;
        int         par;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    itf_rx_if #(.PACK_SIZE(8)) bus_a ();
    itf_rx_if #(.PACK_SIZE(8)) bus_b ();

    itf_rx #(.CLK_PER_BIT(CPB), .PACK_SIZE(8), .PARITY_EN(1'b1), .EVEN_PAR(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .rx  (bus_a.slave)
    );

    itf_rx #(.CLK_PER_BIT(CPB), .PACK_SIZE(8), .PARITY_EN(1'b0), .EVEN_PAR(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .rx  (bus_b.slave)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic prev_act[2] = '{1'b0, 1'b0};
    int   par_cnt[2]  = '{0, 0};
    int   rise_cyc[2] = '{0, 0};

    task automatic chk(input int id, input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL dut%0d %s: got 0x%0h, want 0x%0h (t=%0t)", id, name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic v, input logic s, input int p);
        exp_t e;
        e.data  = d;
        e.valid = v;
        e.stop  = s;
        e.par   = p;
        return e;
    endfunction

    function automatic void push(input int id, input exp_t e);
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endfunction

    function automatic logic active(input int id);
        return (id == 0) ? bus_a.rx_active : bus_b.rx_active;
    endfunction

    task automatic set_line(input int id, input logic v);
        if (id == 0) bus_a.rx_bit = v;
        else         bus_b.rx_bit = v;
    endtask

    // Every rx_active fall ends a frame (good, bad, false start or reset abort).
    task automatic mon(input int id, input logic act, input logic v, input logic pe,
                       input logic se, input logic [7:0] d);
        exp_t e;
        int   qsz;
        if (pe) par_cnt[id]++;
        if (!prev_act[id] && act) rise_cyc[id] = cyc;
        if (prev_act[id] && !act) begin
            qsz = (id == 0) ? q_a.size() : q_b.size();
            if (qsz == 0) begin
                chk(id, "unexpected_frame", 1, 0);
            end else begin
                if (id == 0) e = q_a.pop_front();
                else         e = q_b.pop_front();
                chk(id, "data", int'(d), int'(e.data));
                chk(id, "valid", int'(v), int'(e.valid));
                chk(id, "stop_error", int'(se), int'(e.stop));
                chk(id, "par_error_pulses", par_cnt[id], e.par);
                if (v) chk(id, "valid_latency", cyc - rise_cyc[id], (id == 0) ? LAT_A : LAT_B);
            end
            par_cnt[id] = 0;
        end else if (v || se) begin
            chk(id, "stray_pulse", int'({v, se}), 0);
        end
        prev_act[id] = act;
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.rx_active, bus_a.rx_byte_valid, bus_a.par_error, bus_a.stop_error, bus_a.rx_byte_data);
        mon(1, bus_b.rx_active, bus_b.rx_byte_valid, bus_b.par_error, bus_b.stop_error, bus_b.rx_byte_data);
    end

    // Line fall must show up on rx_active exactly 3 cycles later.
    task automatic start_edge(input int id);
        set_line(id, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk(id, "active_early", int'(active(id)), 0);
        @(negedge clk);
        chk(id, "active_rise", int'(active(id)), 1);
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic has_par,
                        input logic par_b, input logic stop_b, input int gap);
        repeat (gap) @(negedge clk);
        start_edge(id);
        repeat (CPB - 3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(id, d[i]);
            repeat (CPB) @(negedge clk);
        end
        if (has_par) begin
            set_line(id, par_b);
            repeat (CPB) @(negedge clk);
        end
        set_line(id, stop_b);
        repeat (CPB) @(negedge clk);
        set_line(id, 1'b1);
    endtask

    initial begin
        bus_a.rx_bit = 1'b1;
        bus_b.rx_bit = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk(0, "rst_data", int'(bus_a.rx_byte_data), 0);
        chk(0, "rst_valid", int'(bus_a.rx_byte_valid), 0);
        chk(0, "rst_active", int'(bus_a.rx_active), 0);
        chk(0, "rst_par_error", int'(bus_a.par_error), 0);
        chk(0, "rst_stop_error", int'(bus_a.stop_error), 0);
        chk(1, "rst_data", int'(bus_b.rx_byte_data), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good frame, then a bad-parity frame back to back.
        push(0, mk(8'hFE, 1'b1, 1'b0, 0));
        send(0, 8'hFE, 1'b1, 1'b0, 1'b1, 0);
        push(0, mk(8'hFE, 1'b0, 1'b0, ERR));
        send(0, 8'hFE, 1'b1, 1'b1, 1'b1, 0);

        // Low stop bit; the line still low on the first IDLE cycle restarts START, which then aborts.
        push(0, mk(8'hFE, 1'b0, ERR[0], 0));
        push(0, mk(8'hFE, 1'b0, 1'b0, 0));
        send(0, 8'hFE, 1'b1, 1'b0, 1'b0, 10);

        // Glitch shorter than half a bit.
        repeat (10) @(negedge clk);
        push(0, mk(8'hFE, 1'b0, 1'b0, 0));
        set_line(0, 1'b0);
        @(negedge clk);
        set_line(0, 1'b1);
        @(negedge clk);
        chk(0, "glitch_active_early", int'(bus_a.rx_active), 0);
        @(negedge clk);
        chk(0, "glitch_active_rise", int'(bus_a.rx_active), 1);

        // Reset in the middle of the data bits.
        repeat (10) @(negedge clk);
        start_edge(0);
        repeat (4 * CPB - 3) @(negedge clk);
        chk(0, "pre_rst_active", int'(bus_a.rx_active), 1);
        push(0, mk(8'h00, 1'b0, 1'b0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_line(0, 1'b1);
        chk(0, "abort_data", int'(bus_a.rx_byte_data), 0);
        chk(0, "abort_active", int'(bus_a.rx_active), 0);
        chk(0, "abort_valid", int'(bus_a.rx_byte_valid), 0);
        chk(0, "abort_errors", int'({bus_a.par_error, bus_a.stop_error}), 0);

        push(0, mk(8'h5A, 1'b1, 1'b0, 0));
        send(0, 8'h5A, 1'b1, 1'b1, 1'b1, 10);

        // No-parity instance.
        push(1, mk(8'h81, 1'b1, 1'b0, 0));
        send(1, 8'h81, 1'b0, 1'b0, 1'b1, 10);
        push(1, mk(8'h3C, 1'b0, ERR[0], 0));
        push(1, mk(8'h3C, 1'b0, 1'b0, 0));
        send(1, 8'h3C, 1'b0, 1'b0, 1'b0, 10);
        push(1, mk(8'hC5, 1'b1, 1'b0, 0));
        send(1, 8'hC5, 1'b0, 1'b0, 1'b1, 10);

        repeat (30) @(negedge clk);
        chk(0, "frames_outstanding", q_a.size(), 0);
        chk(1, "frames_outstanding", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
